// File: rtl/seg_scan_pkg.sv
// Shared definitions for the display scan decoder: hex glyph table,
// segment bit positions and the nibble type.
package seg_scan_pkg;

    typedef logic [3:0] nibble_t;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [6:0] HEX_GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-nibble lookup; hit is low for any pattern
// outside the hex table, including a blank glyph.
module seg_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] glyph,
    output nibble_t    value,
    output logic       hit
);

    always_comb begin
        value = '0;
        hit   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!hit && glyph == HEX_GLYPHS[i]) begin
                value = 4'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 7-segment scan and rebuilds the four displayed
// hex digits, with frame, glyph, select and stall reporting.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_display,
    input  logic [3:0]  digit_select,
    output logic [15:0] digit_values,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        seg_error,
    output logic        sel_error,
    output logic        scan_timeout
);

    logic [6:0]  s_seg, p_seg, n_seg;
    logic [3:0]  s_sel, p_sel, n_sel;
    logic        primed, captured, changed, fire;
    logic        good, bad, multi;
    logic [7:0]  stable_cnt, cnt_nxt;
    logic [3:0]  seen, seen_nxt;
    logic [15:0] idle_cnt;
    logic [2:0]  sel_count;
    logic [1:0]  sel_idx;
    nibble_t     dec_value;
    logic        dec_hit;

    seg_glyph_decode u_decode (
        .glyph (n_seg),
        .value (dec_value),
        .hit   (dec_hit)
    );

    always_comb begin
        n_seg = SEG_ACTIVE_LOW ? ~s_seg : s_seg;
        n_sel = SEL_ACTIVE_LOW ? ~s_sel : s_sel;
        sel_count = '0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sel_count = sel_count + 3'(n_sel[i]);
            if (n_sel[i]) sel_idx = 2'(i);
        end
        // stable_cnt == 0 only right after reset: no previous sample to match
        changed = (stable_cnt == '0) || (n_seg != p_seg) || (n_sel != p_sel);
        if (changed)
            cnt_nxt = 8'd1;
        else if (stable_cnt == 8'(SETTLE_CYCLES))
            cnt_nxt = stable_cnt;
        else
            cnt_nxt = stable_cnt + 8'd1;
        // Capture on the edge the window completes, giving SETTLE+1 edge latency
        fire  = primed && (cnt_nxt == 8'(SETTLE_CYCLES)) && (changed || !captured);
        good  = fire && (sel_count == 3'd1) && dec_hit;
        bad   = fire && (sel_count == 3'd1) && !dec_hit;
        multi = fire && (sel_count > 3'd1);
        seen_nxt = seen;
        if (good) seen_nxt[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_seg        <= '0;
            s_sel        <= '0;
            p_seg        <= '0;
            p_sel        <= '0;
            primed       <= 1'b0;
            captured     <= 1'b0;
            stable_cnt   <= '0;
            seen         <= '0;
            idle_cnt     <= '0;
            digit_values <= '0;
            digit_valid  <= '0;
            frame_done   <= 1'b0;
            seg_error    <= 1'b0;
            sel_error    <= 1'b0;
            scan_timeout <= 1'b0;
        end else begin
            s_seg     <= seg_display;
            s_sel     <= digit_select;
            primed    <= 1'b1;
            seg_error <= bad;
            sel_error <= multi;

            if (primed) begin
                p_seg      <= n_seg;
                p_sel      <= n_sel;
                stable_cnt <= cnt_nxt;
                if (fire)
                    captured <= 1'b1;
                else if (changed)
                    captured <= 1'b0;
            end

            if (seen_nxt == 4'b1111) begin
                frame_done <= 1'b1;
                seen       <= '0;
            end else begin
                frame_done <= 1'b0;
                seen       <= seen_nxt;
            end

            if (idle_cnt != 16'(TIMEOUT_CYCLES - 1))
                idle_cnt <= idle_cnt + 16'd1;
            if (idle_cnt == 16'(TIMEOUT_CYCLES - 2)) begin
                scan_timeout <= 1'b1;
                digit_valid  <= '0;
            end

            if (bad)
                digit_valid[sel_idx] <= 1'b0;

            if (good) begin
                digit_values[{sel_idx, 2'b00} +: 4] <= dec_value;
                digit_valid[sel_idx] <= 1'b1;
                idle_cnt             <= '0;
                scan_timeout         <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side companion to the display driver in `top`. It samples the multiplexed `seg_display`/`digit_select` outputs on the same clock and reconstructs the four displayed hex digits, with per-digit valid flags. It also reports frame completion, undecodable glyphs, select faults and a stalled scan. It sits in testbenches and in the self-check harness next to `top`, and drives nothing inside `top`.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before a capture. Range 1..255.
- `TIMEOUT_CYCLES`, default 4096: cycles without a capture before `scan_timeout` asserts. Range 2..65535.
- `SEL_ACTIVE_LOW`, default 1: `digit_select` is one-cold when 1 and one-hot when 0.
- `SEG_ACTIVE_LOW`, default 1: a segment is lit when its bit is 0.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `seg_display` in 7: segment bits {g,f,e,d,c,b,a}; bit 0 = a.
- `digit_select` in 4: digit enable; bit i selects digit i.
- `digit_values` out 16: captured nibbles; digit i is at [4i+3:4i].
- `digit_valid` out 4: bit i = digit i holds a decoded value.
- `frame_done` out 1: one-cycle pulse when all four digits have been captured since the last pulse.
- `seg_error` out 1: one-cycle pulse when a glyph is not in the hex table.
- `sel_error` out 1: one-cycle pulse when more than one digit is selected in a stable window.
- `scan_timeout` out 1: sticky level, cleared by the next successful capture or by reset.

## Operation
- Stage 0 registers the inputs into `s_seg` and `s_sel`, then normalises polarity so that 1 means lit or selected.
- Stability counter:
  - Resets to 1 when (`s_seg`, `s_sel`) differs from the previous sample.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A `captured` flag permits exactly one capture per stable window. The flag clears when the inputs change.
- Capture fires when the counter reaches SETTLE_CYCLES and `captured` = 0. Actions depend on the select pattern:
  - Zero bits selected (blanking): no action and no error; the timeout counter keeps running.
  - Two or more bits selected: pulse `sel_error`; no digit is updated.
  - Exactly one bit i selected, glyph matches the table: write the nibble to `digit_values[i]`, set `digit_valid[i]`, set `seen[i]`, and clear the timeout counter and `scan_timeout`.
  - Exactly one bit i selected, glyph not in the table: pulse `seg_error`, clear `digit_valid[i]`, leave `digit_values[i]` unchanged, leave `seen[i]` unchanged.
- Hex table, active-high {g..a}, for values 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Matching is exact; a blank glyph (00) is an error.
- Frame tracking:
  - When `seen` becomes 4'b1111, pulse `frame_done` and clear `seen` on the same edge.
  - Re-capturing a digit that is already in `seen` has no effect on `seen`.
- Timeout: a 16-bit counter increments every cycle and clears on each good capture. When it reaches TIMEOUT_CYCLES-1, set `scan_timeout` and clear all `digit_valid` bits. The counter then saturates.
- Reset mid-operation (async assert): all outputs clear immediately. After release, the first capture needs a full SETTLE_CYCLES window.

## Timing
- Reset values:
  - `digit_values` = 0, `digit_valid` = 0.
  - `frame_done`, `seg_error`, `sel_error`, `scan_timeout` = 0.
  - `seen` = 0, stability counter = 0, `captured` = 0.
- Latency: an input change held stable first appears on outputs SETTLE_CYCLES+1 rising edges after the change (1 edge input register + SETTLE_CYCLES edges of stability).
- All outputs are registered and change only on a `clk` rising edge or on `reset` assertion.
- Pulses are exactly one cycle wide. `frame_done` may coincide with the capture that completes the frame.
- A window shorter than SETTLE_CYCLES samples is ignored silently.

## Structure
- Shared package `seg_scan_pkg`:
  - the 16-entry hex glyph constant array;
  - the segment bit-index constants a..g;
  - the 4-bit nibble typedef.
- Sub-module `seg_glyph_decode`: combinational, 7-bit glyph in, nibble plus `hit` out. This is the only sub-module.
- The stability, capture, frame and timeout logic stays in `seg_scan_decoder`.

## Test plan
- **Reset:** assert `reset` for 3 cycles with random inputs → all outputs 0; `digit_valid` = 0000.
- **Clean scan, defaults:** drive digits 1,2,3,4 on digit 0..3, each held 8 cycles, one-cold select → `digit_values` = 16'h4321, `digit_valid` = 1111, one `frame_done` pulse.
- **Glitch:** hold a glyph for only 3 cycles, then a stable window → no capture during the short window; `seg_error` never pulses.
- **Bad glyph:** digit 2 stable with pattern 7'h00 (raw active-low 7'h7F) → one `seg_error` pulse; `digit_valid[2]` = 0; other digits unchanged.
- **Select fault:** `digit_select` = 4'b1100 (two active-low bits) stable for 6 cycles → exactly one `sel_error` pulse; no update.
- **Stall:** inputs frozen with blank select, TIMEOUT_CYCLES = 64 → `scan_timeout` = 1 and `digit_valid` = 0000 at cycle 64. The next good capture clears `scan_timeout`.
